soc_nios_oci_ram_arbiter: RTL
=============================

SOC_NIOS_OCI_RAM_ARBITER -- requirements
Module: soc_nios_oci_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, OCI debug RAM word-address width.
REQ-002 Parameter DATA_W, default 32, OCI debug RAM data width.
REQ-003 clk  in  1  single clock, shared with the Nios II core; all logic is rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 jtag_req  in  1  JTAG-side (sysclk domain, take_action_ocimem decode) request valid; held until jtag_ack.
REQ-006 jtag_wr  in  1  1 = write, 0 = read; stable while jtag_req=1.
REQ-007 jtag_addr  in  ADDR_W  JTAG word address; stable while jtag_req=1.
REQ-008 jtag_wdata  in  DATA_W  JTAG write data; stable while jtag_req=1.
REQ-009 jtag_ack  out  1  one-cycle completion pulse to JTAG requester.
REQ-010 av_req, av_wr, av_addr, av_wdata  in  1/1/ADDR_W/DATA_W  CPU Avalon-side request, same rules as JTAG.
REQ-011 av_ack  out  1  one-cycle completion pulse to Avalon requester.
REQ-012 rdata  out  DATA_W  read result; valid in the ack cycle of a read, held until next read completes.
REQ-013 debugack  in  1  CPU is in debug mode; used only under REQ-034.
REQ-014 ram_addr, ram_wdata  out  ADDR_W/DATA_W  shared RAM port address/data, registered.
REQ-015 ram_we, ram_re  out  1/1  registered write/read strobes, never both high.
REQ-016 ram_rdata  in  DATA_W  RAM read data, valid exactly one cycle after ram_re.

Function
REQ-017 FSM states IDLE, ACCESS, WAIT, RESP; one transaction in flight at a time.
REQ-018 IDLE: if any req=1, select winner, register ram_* from winner's fields, go ACCESS; else stay IDLE with ram_we=ram_re=0.
REQ-019 ACCESS: exactly one cycle of ram_we (write) or ram_re (read); write -> RESP, read -> WAIT.
REQ-020 WAIT: ram_rdata captured into rdata; go RESP.
REQ-021 RESP: winner's ack=1 for exactly this cycle; ram_we=ram_re=0; go IDLE.
REQ-022 Latency, request sampled in IDLE at cycle N: write ack at N+2, read ack at N+3.
REQ-023 The loser's ack SHALL never pulse; the loser's request stays pending and is served next.
REQ-024 req still high in the IDLE cycle after its ack is treated as a new transaction.
REQ-025 Arbitration 2-way round-robin: single request wins; simultaneous requests go to the requester not granted last.
REQ-026 last_grant updates only on the IDLE->ACCESS transition.
REQ-027 jtag_ack and av_ack never high in the same cycle.
REQ-028 Fields of a requester are captured at grant; changes after grant do not affect the access.
REQ-029 A requester dropping req before ack (protocol violation) does not abort the in-flight access; ack still pulses.

Reset
REQ-030 reset=1: state=IDLE, last_grant=AV (JTAG wins first tie), jtag_ack=av_ack=0, ram_we=ram_re=0, ram_addr=0, ram_wdata=0, rdata=0.
REQ-031 reset asserted mid-transaction abandons it: no ack is issued and no RAM strobe occurs in the following cycle.
REQ-032 First possible grant is in the first cycle with reset=0.

Configuration
REQ-033 Macro SOC_NIOS_OCI_ARB_DEBUG_LOCK_EN selects the debug-lock feature.
REQ-034 Defined: while debugack=1 in IDLE, only jtag_req is granted; av_req waits; an Avalon access already past IDLE completes normally; round-robin resumes when debugack=0.
REQ-035 Undefined: debugack is ignored (port present, unloaded); pure round-robin.

Structure
REQ-036 Package soc_nios_oci_arb_pkg holds the FSM state enum, requester-id enum (JTAG, AV), and ADDR_W/DATA_W defaults.
REQ-037 One sub-module soc_nios_oci_rr_pick: combinational 2-way round-robin winner from (jtag_req, av_req, last_grant, lock).

Verification
REQ-038 JTAG write addr 0x10 data 0xDEADBEEF at N -> ram_we=1 at N+1 with those values, jtag_ack at N+2 only.
REQ-039 Avalon read addr 0x10 after REQ-038 write -> ram_re at N+1, av_ack at N+3 with rdata=0xDEADBEEF, held afterwards.
REQ-040 Both req held high from reset release, both reads -> acks alternate JTAG, AV, JTAG, AV; never coincident.
REQ-041 Reset pulsed in WAIT of a read -> no ack, ram_re=0, rdata=0; next tie granted to JTAG.
REQ-042 With SOC_NIOS_OCI_ARB_DEBUG_LOCK_EN, debugack=1, both req high -> only jtag_ack pulses; debugack=0 -> av_ack follows next.

Source files
------------

// File: rtl/soc_nios_oci_arb_pkg.sv
// Shared types and defaults for the OCI debug RAM arbiter.
package soc_nios_oci_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_JTAG = 1'b0,
    REQ_AV   = 1'b1
  } req_id_e;

endpackage

// File: rtl/soc_nios_oci_rr_pick.sv
// Combinational 2-way round-robin pick; lock masks the Avalon requester.
module soc_nios_oci_rr_pick
  import soc_nios_oci_arb_pkg::*;
(
  input  logic    jtag_req,
  input  logic    av_req,
  input  req_id_e last_grant,
  input  logic    lock,
  output logic    vld,
  output req_id_e winner
);

  logic av_ok;

  always_comb begin
    av_ok = av_req & ~lock;
    vld   = jtag_req | av_ok;
    if (jtag_req && av_ok)
      winner = (last_grant == REQ_JTAG) ? REQ_AV : REQ_JTAG;
    else if (jtag_req)
      winner = REQ_JTAG;
    else
      winner = REQ_AV;
  end

endmodule

// File: rtl/soc_nios_oci_ram_arbiter.sv
// Arbitrates JTAG and Avalon access to the single-port OCI debug RAM.
// Define SOC_NIOS_OCI_ARB_DEBUG_LOCK_EN to hold off Avalon grants while debugack=1.
module soc_nios_oci_ram_arbiter
  import soc_nios_oci_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_ack,
  input  logic              av_req,
  input  logic              av_wr,
  input  logic [ADDR_W-1:0] av_addr,
  input  logic [DATA_W-1:0] av_wdata,
  output logic              av_ack,
  output logic [DATA_W-1:0] rdata,
  input  logic              debugack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state, next_state;
  req_id_e           last_grant, cur_id, pick_id;
  logic              cur_wr, pick_vld, lock;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef SOC_NIOS_OCI_ARB_DEBUG_LOCK_EN
  assign lock = debugack;
`else
  assign lock = debugack & 1'b0;
`endif

  soc_nios_oci_rr_pick u_pick (
    .jtag_req   (jtag_req),
    .av_req     (av_req),
    .last_grant (last_grant),
    .lock       (lock),
    .vld        (pick_vld),
    .winner     (pick_id)
  );

  always_comb begin
    sel_wr    = (pick_id == REQ_JTAG) ? jtag_wr    : av_wr;
    sel_addr  = (pick_id == REQ_JTAG) ? jtag_addr  : av_addr;
    sel_wdata = (pick_id == REQ_JTAG) ? jtag_wdata : av_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Acks decode straight from state; reset gating keeps them quiet mid-abort.
  always_comb begin
    next_state = state;
    jtag_ack   = 1'b0;
    av_ack     = 1'b0;
    case (state)
      S_IDLE:   if (pick_vld) next_state = S_ACCESS;
      S_ACCESS: next_state = cur_wr ? S_RESP : S_WAIT;
      S_WAIT:   next_state = S_RESP;
      S_RESP: begin
        next_state = S_IDLE;
        jtag_ack   = ~reset & (cur_id == REQ_JTAG);
        av_ack     = ~reset & (cur_id == REQ_AV);
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // Request fields are latched at grant, so later changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_AV;
      cur_id     <= REQ_JTAG;
      cur_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      rdata      <= '0;
    end else begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      case (state)
        S_IDLE: if (pick_vld) begin
          last_grant <= pick_id;
          cur_id     <= pick_id;
          cur_wr     <= sel_wr;
          ram_addr   <= sel_addr;
          ram_wdata  <= sel_wdata;
          ram_we     <= sel_wr;
          ram_re     <= ~sel_wr;
        end
        S_WAIT:  rdata <= ram_rdata;
        default: ;
      endcase
    end
  end

endmodule
